// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: fetch entry layout,
// PC increment and the counter-width helper used for FIFO occupancy/credit counters.
package fetch_pkg;

  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_ADDR_W  = 32;
  localparam int INSTR_BYTES   = 4;
  localparam logic [FETCH_ADDR_W-1:0] PC_INCR = FETCH_ADDR_W'(INSTR_BYTES);

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset, flush and occupancy count.
// Flush wins over push/pop; head data is presented combinationally on pop_data.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush)) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word reads under a credit limit,
// buffers returned words with their PC and hands them to decode; redirects flush and drop.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    INSTR_WIDTH = FETCH_INSTR_W,
  parameter int                    ADDR_WIDTH  = FETCH_ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  // Both channels: a transfer happens on a cycle where valid && ready at the rising edge;
  // valid never depends on ready of the same channel, and payload holds while valid && !ready.
  logic                  req_fire, pop, rsp_keep;
  logic [CW-1:0]         outstanding, drop_cnt, buf_count, pend_count;
  logic [CW:0]           in_use;
  logic [ADDR_WIDTH-1:0] fetch_pc, pend_head;
  fetch_entry_t          push_entry, head_entry;

  assign pop      = instr_valid && instr_ready;
  // Credit counts words in flight plus words buffered, net of the one leaving this cycle.
  assign in_use   = {1'b0, outstanding} + {1'b0, buf_count} - (CW+1)'(pop);
  assign imem_req_valid = !rst && !redirect && (in_use < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign rsp_keep   = imem_rsp_valid && !redirect && (drop_cnt == '0);
  assign push_entry = '{instr: imem_rsp_data, pc: pend_head};

  assign instr_valid = !rst && (buf_count != '0);
  assign instr       = instr_valid ? head_entry.instr : '0;
  assign instr_pc    = instr_valid ? head_entry.pc    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_target & ~ADDR_WIDTH'(3);
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + PC_INCR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  // On redirect every response still in flight (excluding one arriving now) is stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= outstanding - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .pop_data  (pend_head),
    .count     (pend_count)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (buf_count)
  );

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && (buf_count == CW'(FIFO_DEPTH))));
  a_pend_has_pc: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && (pend_count == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model with configurable latency, program-order
// reference model for request addresses and delivered words, directed then random steps.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] redirect_target, imem_req_addr, imem_rsp_data, instr, instr_pc;

  instr_fetch_unit #(
    .INSTR_WIDTH (32),
    .ADDR_WIDTH  (32),
    .RESET_PC    (RESET_PC),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_next_pc, exp_req_pc;
  int          cyc, lat;
  int          n_cmp, n_bad;
  int          req_fires, dec_fires, dec_total;
  int          first_req_cyc, first_valid_cyc;
  logic        redir_wait, saw_wrap, have_last_req, prev_stall, want_first_req;
  logic [31:0] first_pc_after_redir, last_req_addr, prev_stall_addr, first_req_after_rst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard + reference model, evaluated mid-cycle on settled signals
  task automatic monitor();
    logic [63:0] e;
    mreq_t       m;
    if (rst) begin
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_instr_valid", 64'(instr_valid), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);
      check("rst_instr_pc", 64'(instr_pc), 64'd0);
      mem_q.delete();
      exp_q.delete();
      exp_next_pc = RESET_PC;
      exp_req_pc = RESET_PC;
      req_fires = 0;
      dec_fires = 0;
      first_req_cyc = -1;
      first_valid_cyc = -1;
      prev_stall = 1'b0;
      have_last_req = 1'b0;
      want_first_req = 1'b1;
      return;
    end
    if (!instr_valid) check("idle_zero", {instr, instr_pc}, 64'd0);
    else if (first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && imem_req_valid && !redirect)
      check("addr_stable", 64'(imem_req_addr), 64'(prev_stall_addr));
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back({mem_word(exp_next_pc), exp_next_pc});
        exp_next_pc += 32'd4;
      end
      e = exp_q.pop_front();
      check("dec_pc", 64'(instr_pc), 64'(e[31:0]));
      check("dec_instr", 64'(instr), 64'(e[63:32]));
      dec_fires++;
      dec_total++;
      if (redir_wait) begin
        first_pc_after_redir = instr_pc;
        redir_wait = 1'b0;
      end
    end
    if (redirect) begin
      check("no_req_in_redirect", 64'(imem_req_valid), 64'd0);
      exp_q.delete();
      exp_next_pc = redirect_target & 32'hFFFF_FFFC;
      exp_req_pc = exp_next_pc;
      redir_wait = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", 64'(imem_req_addr), 64'(exp_req_pc));
        exp_req_pc += 32'd4;
        if (have_last_req && last_req_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0)
          saw_wrap = 1'b1;
        last_req_addr = imem_req_addr;
        have_last_req = 1'b1;
        m.addr = imem_req_addr;
        m.due = cyc + lat;
        if (mem_q.size() != 0 && m.due <= mem_q[$].due) m.due = mem_q[$].due + 1;
        mem_q.push_back(m);
        req_fires++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (want_first_req) begin
          first_req_after_rst = imem_req_addr;
          want_first_req = 1'b0;
        end
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_stall_addr = imem_req_addr;
    end
  endtask

  // driver: one clock cycle; caller sets rst/redirect/ready inputs beforehand
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int d0;
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; dec_total = 0;
    saw_wrap = 1'b0; redir_wait = 1'b0; first_pc_after_redir = '0;
    first_req_after_rst = 32'hDEAD_BEEF;
    rst = 1'b1; redirect = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clk); #1;
    steps(3);

    // streaming, latency 1
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    steps(10);
    check("first_req_addr", 64'(first_req_after_rst), 64'(RESET_PC));
    check("first_instr_latency", 64'(first_valid_cyc - first_req_cyc), 64'd2);
    d0 = dec_fires;
    steps(20);
    check("throughput_20", 64'(dec_fires - d0), 64'd20);

    // decode stall: buffer fills, requests stop
    instr_ready = 1'b0;
    steps(10);
    #1;
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_buffered", 64'(req_fires - dec_fires - mem_q.size() - int'(imem_rsp_valid)), 64'd4);
    instr_ready = 1'b1;
    steps(20);

    // latency 3, redirect with two requests in flight
    rst = 1'b1; step(); rst = 1'b0;
    lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
    steps(2);
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h100;
    #1;
    check("inflight_at_redirect", 64'(mem_q.size()), 64'd2);
    step();
    redirect = 1'b0; imem_req_ready = 1'b1;
    #1;
    check("redir_req_valid", 64'(imem_req_valid), 64'd1);
    check("redir_req_addr", 64'(imem_req_addr), 64'h100);
    steps(15);
    check("redir_first_pc", 64'(first_pc_after_redir), 64'h100);

    // unaligned target, redirect coinciding with a decode handshake
    lat = 1;
    steps(4);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (instr_valid) break;
      step();
    end
    check("valid_before_redirect", 64'(instr_valid), 64'd1);
    redirect = 1'b1; redirect_target = 32'h203;
    step();
    redirect = 1'b0;
    #1;
    check("aligned_req_addr", 64'(imem_req_addr), 64'h200);
    steps(10);
    check("aligned_first_pc", 64'(first_pc_after_redir), 64'h200);

    // PC wrap
    redirect = 1'b1; redirect_target = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    steps(12);
    check("pc_wrap", 64'(saw_wrap), 64'd1);

    // reset mid-stream with three outstanding
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_q.size() + int'(imem_rsp_valid) == 3) break;
      step();
    end
    check("outstanding_before_rst", 64'(mem_q.size() + int'(imem_rsp_valid)), 64'd3);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    #1;
    check("post_rst_instr_valid", 64'(instr_valid), 64'd0);
    check("post_rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    steps(12);
    check("post_rst_first_req", 64'(first_req_after_rst), 64'(RESET_PC));

    // randomized phases
    for (int ph = 0; ph < 8; ph++) begin
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 80; i++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        instr_ready = ($urandom_range(0, 2) != 0);
        redirect = ($urandom_range(0, 24) == 0);
        redirect_target = ($urandom_range(0, 7) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        rst = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    rst = 1'b0; redirect = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    steps(20);
    check("enough_traffic", 64'(dec_total > 150), 64'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
